pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning consecutive unacknowledged data-memory cycles before halt (2..65535).
REQ-002 SHALL have parameter CNT_W, default 32, meaning statistics counter width.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have port instruction_ID  in  32  instruction in ID.
REQ-006 SHALL have ports rd_ex  in  5, we_rf_ex  in  1 and mem_read_ex  in  1, giving the EX instruction's destination, write-enable and load flag.
REQ-007 SHALL have port branch_taken_ex  in  1  taken branch/jal/jalr resolved in EX.
REQ-008 SHALL have ports dmem_req_mem  in  1  MEM access active, and dmem_ack  in  1  memory completes this cycle.
REQ-009 SHALL have port clr_stats  in  1  zero counters.
REQ-010 SHALL have outputs stall_if (hold PC), stall_id (hold IF/ID), flush_id (IF/ID to NOP), flush_ex (bubble into ID/EX) and freeze_mem (hold ID/EX, EX/MEM, MEM/WB), each 1 bit.
REQ-011 SHALL have outputs stall_cnt and flush_cnt, each CNT_W bits, and mem_timeout, 1 bit, sticky error.

Function
REQ-012 SHALL run FSM states RUN, MEM_WAIT and HALT; control outputs are combinational from state and inputs.
REQ-013 SHALL decode rs1 as used for opcodes R, I, S, B, jalr and load, and rs2 as used for R, S and B; other opcodes use neither.
REQ-014 SHALL define load_use as mem_read_ex & we_rf_ex & rd_ex!=0 & (rs1 used & rs1==rd_ex | rs2 used & rs2==rd_ex).
REQ-015 In RUN with dmem_req_mem=1 and dmem_ack=0, SHALL drive stall_if=stall_id=freeze_mem=1, flush_*=0, and go to MEM_WAIT; redirect and load_use are ignored in this cycle.
REQ-016 Otherwise in RUN, if branch_taken_ex=1, SHALL drive flush_id=flush_ex=1 and stall_*=0, and increment flush_cnt; load_use is ignored.
REQ-017 Otherwise in RUN, if load_use, SHALL drive stall_if=stall_id=flush_ex=1 for exactly one cycle and increment stall_cnt.
REQ-018 In MEM_WAIT with dmem_ack=0, SHALL hold all freezes per REQ-015 and increment stall_cnt each cycle.
REQ-019 In MEM_WAIT with dmem_ack=1, SHALL release the freeze that cycle, evaluate REQ-016/017 as in RUN, and return to RUN.
REQ-020 SHALL set mem_timeout and enter HALT at the edge ending the TIMEOUT-th consecutive cycle with dmem_req_mem=1 and dmem_ack=0, counting the RUN entry cycle.
REQ-021 In HALT, SHALL hold stall_if=stall_id=freeze_mem=1 and flush_*=0 until reset; counters hold.
REQ-022 SHALL saturate counters at all-ones; clr_stats has priority over a same-cycle increment.
REQ-023 SHALL NOT detect hazards on rd_ex=0, nor from the EX instruction when we_rf_ex=0.

Reset
REQ-024 While rst_n=0, SHALL hold all control outputs at 0.
REQ-025 At the reset edge, SHALL set state=RUN, stall_cnt=flush_cnt=0, the wait counter to 0, and mem_timeout=0.
REQ-026 A reset during MEM_WAIT or HALT SHALL return to RUN with no residual freeze in the next cycle.

Structure
REQ-027 SHALL take opcode constants (R_type, I_type, S_type, B_type, I_type_jalr, I_type_lw, J_type) and state encodings from the shared param.v include.
REQ-028 SHALL place the load_use decode (REQ-013/014) in a combinational sub-module, hazard_detect, instantiated once.

Verification
REQ-029 Load-use: ID=0x002081B3 (add x3,x1,x2), rd_ex=1, mem_read_ex=we_rf_ex=1 -> one cycle of stall_if=stall_id=flush_ex=1, and stall_cnt=1.
REQ-030 No-hazard cases: rd_ex=0 or ID=jal (opcode 1101111) with a matching field -> all outputs 0 and stall_cnt=0.
REQ-031 branch_taken_ex=1 together with the REQ-029 load-use -> flush_id=flush_ex=1, stall_if=0, flush_cnt=1, stall_cnt=0.
REQ-032 dmem_req_mem=1 with ack on the 4th cycle -> freeze for 3 cycles, released on the ack cycle, stall_cnt=2, state RUN.
REQ-033 TIMEOUT=4, req=1, ack=0 -> mem_timeout=1 after the 4th edge, held after req drops; one cycle of rst_n=0 clears it.
REQ-034 stall_cnt at all-ones plus load-use -> stays all-ones; clr_stats in the same cycle -> 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and operand-usage helpers
// for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_e;

   localparam logic [6:0] R_type      = 7'b0110011;
   localparam logic [6:0] I_type      = 7'b0010011;
   localparam logic [6:0] S_type      = 7'b0100011;
   localparam logic [6:0] B_type      = 7'b1100011;
   localparam logic [6:0] I_type_jalr = 7'b1100111;
   localparam logic [6:0] I_type_lw   = 7'b0000011;
   localparam logic [6:0] J_type      = 7'b1101111;

   function automatic logic rs1_used(input logic [6:0] op);
      case (op)
         R_type, I_type, S_type, B_type, I_type_jalr, I_type_lw: return 1'b1;
         default:                                                return 1'b0;
      endcase
   endfunction

   function automatic logic rs2_used(input logic [6:0] op);
      case (op)
         R_type, S_type, B_type: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard decode: does the ID instruction read the register a load
// in EX is about to write?
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [31:0] instruction_id,
   input  logic [4:0]  rd_ex,
   input  logic        we_rf_ex,
   input  logic        mem_read_ex,
   output logic        load_use
);

   logic [6:0] opcode;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       hit1;
   logic       hit2;

   assign opcode = instruction_id[6:0];
   assign rs1    = instruction_id[19:15];
   assign rs2    = instruction_id[24:20];

   assign hit1     = rs1_used(opcode) && (rs1 == rd_ex);
   assign hit2     = rs2_used(opcode) && (rs2 == rd_ex);
   assign load_use = mem_read_ex && we_rf_ex && (rd_ex != 5'd0) && (hit1 || hit2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: data-memory wait freeze with timeout halt, taken-branch
// flush, load-use stall, and saturating stall/flush statistics.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instruction_ID,
   input  logic [4:0]       rd_ex,
   input  logic             we_rf_ex,
   input  logic             mem_read_ex,
   input  logic             branch_taken_ex,
   input  logic             dmem_req_mem,
   input  logic             dmem_ack,
   input  logic             clr_stats,
   output logic             stall_if,
   output logic             stall_id,
   output logic             flush_id,
   output logic             flush_ex,
   output logic             freeze_mem,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_timeout
);

   localparam logic [16:0] TIMEOUT_V = 17'(TIMEOUT);

   state_e      state, state_nxt;
   logic [15:0] wait_cnt, wait_nxt;
   logic [16:0] wait_inc;
   logic        load_use;
   logic        inc_stall, inc_flush, timeout_hit;

   hazard_detect u_hazard (
      .instruction_id (instruction_ID),
      .rd_ex          (rd_ex),
      .we_rf_ex       (we_rf_ex),
      .mem_read_ex    (mem_read_ex),
      .load_use       (load_use)
   );

   assign wait_inc = {1'b0, wait_cnt} + 17'd1;

   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      inc_stall   = 1'b0;
      inc_flush   = 1'b0;
      timeout_hit = 1'b0;
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      flush_id    = 1'b0;
      flush_ex    = 1'b0;
      freeze_mem  = 1'b0;
      case (state)
         RUN, MEM_WAIT: begin
            // A pending memory access outranks redirects and load-use.
            if (!dmem_ack && (state == MEM_WAIT || dmem_req_mem)) begin
               stall_if   = 1'b1;
               stall_id   = 1'b1;
               freeze_mem = 1'b1;
               inc_stall  = (state == MEM_WAIT);
               wait_nxt   = wait_inc[15:0];
               if (wait_inc == TIMEOUT_V) begin
                  timeout_hit = 1'b1;
                  state_nxt   = HALT;
               end else begin
                  state_nxt = MEM_WAIT;
               end
            end else begin
               wait_nxt  = 16'd0;
               state_nxt = RUN;
               if (branch_taken_ex) begin
                  flush_id  = 1'b1;
                  flush_ex  = 1'b1;
                  inc_flush = 1'b1;
               end else if (load_use) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  flush_ex  = 1'b1;
                  inc_stall = 1'b1;
               end
            end
         end
         default: begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            freeze_mem = 1'b1;
         end
      endcase
      if (!rst_n) begin
         stall_if   = 1'b0;
         stall_id   = 1'b0;
         flush_id   = 1'b0;
         flush_ex   = 1'b0;
         freeze_mem = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (timeout_hit) mem_timeout <= 1'b1;
         if (clr_stats)                          stall_cnt <= '0;
         else if (inc_stall && stall_cnt != '1)  stall_cnt <= stall_cnt + 1'b1;
         if (clr_stats)                          flush_cnt <= '0;
         else if (inc_flush && flush_cnt != '1)  flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a cycle-level
// behavioural model of the stall/flush/timeout rules.
module tb_pipeline_ctrl;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 4;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [31:0]      instruction_ID;
   logic [4:0]       rd_ex;
   logic             we_rf_ex, mem_read_ex, branch_taken_ex;
   logic             dmem_req_mem, dmem_ack, clr_stats;
   logic             stall_if, stall_id, flush_id, flush_ex, freeze_mem;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic             mem_timeout;

   int checks = 0;
   int errors = 0;

   // model state
   bit m_wait, m_halt, m_to;
   int m_run, m_scnt, m_fcnt;

   pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .instruction_ID  (instruction_ID),
      .rd_ex           (rd_ex),
      .we_rf_ex        (we_rf_ex),
      .mem_read_ex     (mem_read_ex),
      .branch_taken_ex (branch_taken_ex),
      .dmem_req_mem    (dmem_req_mem),
      .dmem_ack        (dmem_ack),
      .clr_stats       (clr_stats),
      .stall_if        (stall_if),
      .stall_id        (stall_id),
      .flush_id        (flush_id),
      .flush_ex        (flush_ex),
      .freeze_mem      (freeze_mem),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt),
      .mem_timeout     (mem_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit ref_load_use(input logic [31:0] ins, input logic [4:0] rd,
                                       input bit mr, input bit we);
      bit u1, u2;
      case (ins[6:0])
         7'b0110011, 7'b0100011, 7'b1100011: begin u1 = 1; u2 = 1; end
         7'b0010011, 7'b1100111, 7'b0000011: begin u1 = 1; u2 = 0; end
         default:                            begin u1 = 0; u2 = 0; end
      endcase
      return mr && we && rd != 0 &&
             ((u1 && ins[19:15] == rd) || (u2 && ins[24:20] == rd));
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic model_reset();
      m_wait = 0; m_halt = 0; m_to = 0; m_run = 0; m_scnt = 0; m_fcnt = 0;
   endtask

   // Inputs are already applied; check outputs mid-cycle, then clock and advance model.
   task automatic step();
      bit e_sif, e_sid, e_fid, e_fex, e_frz, inc_s, inc_f, blocked, lu;
      #3;
      e_sif = 0; e_sid = 0; e_fid = 0; e_fex = 0; e_frz = 0; inc_s = 0; inc_f = 0;
      lu = ref_load_use(instruction_ID, rd_ex, mem_read_ex, we_rf_ex);
      blocked = m_wait ? !dmem_ack : (dmem_req_mem && !dmem_ack);
      if (m_halt) begin
         e_sif = 1; e_sid = 1; e_frz = 1;
      end else if (blocked) begin
         e_sif = 1; e_sid = 1; e_frz = 1; inc_s = m_wait;
      end else if (branch_taken_ex) begin
         e_fid = 1; e_fex = 1; inc_f = 1;
      end else if (lu) begin
         e_sif = 1; e_sid = 1; e_fex = 1; inc_s = 1;
      end
      if (!rst_n) begin
         e_sif = 0; e_sid = 0; e_fid = 0; e_fex = 0; e_frz = 0;
      end
      check("stall_if", stall_if, e_sif);
      check("stall_id", stall_id, e_sid);
      check("flush_id", flush_id, e_fid);
      check("flush_ex", flush_ex, e_fex);
      check("freeze_mem", freeze_mem, e_frz);
      check("stall_cnt", stall_cnt, m_scnt);
      check("flush_cnt", flush_cnt, m_fcnt);
      check("mem_timeout", mem_timeout, m_to);
      @(posedge clk);
      #1;
      if (!rst_n) begin
         model_reset();
      end else begin
         if (!m_halt) begin
            if (blocked) begin
               m_run++;
               if (m_run == TIMEOUT) begin m_halt = 1; m_to = 1; m_wait = 0; end
               else m_wait = 1;
            end else begin
               m_run = 0; m_wait = 0;
            end
         end
         if (clr_stats) begin m_scnt = 0; m_fcnt = 0; end
         else begin
            if (inc_s) m_scnt = sat_inc(m_scnt);
            if (inc_f) m_fcnt = sat_inc(m_fcnt);
         end
      end
   endtask

   task automatic idle();
      rst_n = 1; instruction_ID = 32'h00000013; rd_ex = 0; we_rf_ex = 0;
      mem_read_ex = 0; branch_taken_ex = 0; dmem_req_mem = 0; dmem_ack = 0;
      clr_stats = 0;
   endtask

   task automatic set_load_use();
      instruction_ID = 32'h002081B3; rd_ex = 5'd1; mem_read_ex = 1; we_rf_ex = 1;
   endtask

   task automatic clear();
      idle(); clr_stats = 1; step(); clr_stats = 0;
   endtask

   initial begin
      logic [6:0] ops [8];
      ops = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b1100011,
              7'b1100111, 7'b0000011, 7'b1101111, 7'b0110111};
      idle();
      rst_n = 0;
      @(posedge clk); #1;
      model_reset();
      step();
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_flush_cnt", flush_cnt, 0);
      check("rst_timeout", mem_timeout, 0);
      idle();

      // load-use: one stall cycle, counted once
      set_load_use(); step();
      idle(); step();
      check("lu_stall_cnt", stall_cnt, 1);

      // rd_ex=0 and jal with matching fields never hazard
      clear();
      set_load_use(); rd_ex = 0; step();
      set_load_use(); instruction_ID = 32'h0010816F; step();
      check("nohaz_cnt", stall_cnt, 0);

      // branch beats load-use
      clear();
      set_load_use(); branch_taken_ex = 1; step();
      check("br_flush_cnt", flush_cnt, 1);
      check("br_stall_cnt", stall_cnt, 0);

      // ack on the 4th cycle of a memory access
      clear();
      dmem_req_mem = 1; step(); step(); step();
      dmem_ack = 1; step();
      idle(); step();
      check("mw_stall_cnt", stall_cnt, 2);

      // timeout after TIMEOUT unacknowledged cycles, sticky, cleared by reset
      idle(); dmem_req_mem = 1;
      repeat (TIMEOUT) step();
      check("to_set", mem_timeout, 1);
      idle(); step(); step();
      check("to_hold", mem_timeout, 1);
      rst_n = 0; step();
      idle(); step();
      check("to_clr", mem_timeout, 0);

      // saturation, then clr beats increment
      set_load_use();
      repeat (CMAX + 2) step();
      check("sat_cnt", stall_cnt, CMAX);
      clr_stats = 1; step();
      clr_stats = 0;
      check("sat_clr", stall_cnt, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n           = ($urandom_range(0, 59) != 0);
         instruction_ID  = {7'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                            3'd0, 5'd5, ops[$urandom_range(0, 7)]};
         rd_ex           = 5'($urandom_range(0, 3));
         we_rf_ex        = ($urandom_range(0, 3) != 0);
         mem_read_ex     = ($urandom_range(0, 1) != 0);
         branch_taken_ex = ($urandom_range(0, 4) == 0);
         dmem_req_mem    = ($urandom_range(0, 2) == 0) || m_wait;
         dmem_ack        = ($urandom_range(0, 9) < 3);
         clr_stats       = !m_halt && ($urandom_range(0, 49) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
